// File: rtl/pong_pkg.sv
// pong_pkg: shared Pong definitions.
//   match_state_t   - match sequencing states for paddle_serve_ctrl
//   *_DEF           - default playfield geometry shared with ball/video blocks
//   paddle_y_reset  - centered paddle top edge for a given geometry
//   PADDLE_Y_RESET  - centered paddle top edge for the default geometry
package pong_pkg;

   typedef enum logic [1:0] {
      SERVE_WAIT = 2'd0,
      PLAY       = 2'd1,
      POINT      = 2'd2,
      GAME_OVER  = 2'd3
   } match_state_t;

   localparam int FIELD_H_DEF  = 480;
   localparam int PADDLE_H_DEF = 64;
   localparam int Y_W_DEF      = 10;

   function automatic int paddle_y_reset(input int field_h, input int paddle_h);
      return (field_h - paddle_h) / 2;
   endfunction

   localparam int PADDLE_Y_RESET = paddle_y_reset(FIELD_H_DEF, PADDLE_H_DEF);

endpackage

// File: rtl/paddle_axis.sv
// paddle_axis: one player's paddle Y.
//   Collects up/down step pulses in a saturating signed accumulator and applies
//   them once per frame as y <- clamp(y + pend*STEP, 0, FIELD_H-PADDLE_H).
// Ports:
//   clk, reset  - clock, synchronous active-high reset
//   frame_tick  - one-cycle pulse per frame; applies and clears the accumulator
//   up, down    - one-cycle step pulses (up = toward y=0)
//   recenter    - forces the paddle back to the centered position
//   y           - top edge of the paddle
module paddle_axis
   import pong_pkg::*;
#(
   parameter int FIELD_H     = FIELD_H_DEF,
   parameter int PADDLE_H    = PADDLE_H_DEF,
   parameter int STEP        = 8,
   parameter int MAX_PENDING = 7,
   parameter int Y_W         = Y_W_DEF
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           frame_tick,
   input  logic           up,
   input  logic           down,
   input  logic           recenter,
   output logic [Y_W-1:0] y
);

   localparam int PW = $clog2(MAX_PENDING + 1) + 1;
   localparam int SW = Y_W + PW + $clog2(STEP + 1) + 2;

   localparam logic signed [PW:0]   PMAX_E = (PW+1)'(MAX_PENDING);
   localparam logic signed [PW:0]   ONE_E  = (PW+1)'(1);
   localparam logic signed [PW-1:0] PMAX   = PW'(MAX_PENDING);
   localparam logic signed [PW-1:0] PMIN   = -PW'(MAX_PENDING);
   localparam logic signed [SW-1:0] STEP_S = SW'(STEP);
   localparam logic signed [SW-1:0] YMAX_S = SW'(FIELD_H - PADDLE_H);
   localparam logic [Y_W-1:0]       YMAX   = Y_W'(FIELD_H - PADDLE_H);
   localparam logic [Y_W-1:0]       Y_RST  = Y_W'(paddle_y_reset(FIELD_H, PADDLE_H));

   logic [Y_W-1:0]       r_y;
   logic signed [PW-1:0] r_pend;
   logic signed [PW-1:0] w_pend_next;
   logic signed [PW:0]   w_pend_sum;
   logic signed [SW-1:0] w_sum;
   logic [Y_W-1:0]       w_y_next;

   // A pulse landing in the tick cycle starts the next frame's accumulator.
   always_comb begin
      w_pend_sum = frame_tick ? '0 : (PW+1)'(r_pend);
      if (up && !down)
         w_pend_sum = w_pend_sum - ONE_E;
      else if (down && !up)
         w_pend_sum = w_pend_sum + ONE_E;
      if (w_pend_sum > PMAX_E)
         w_pend_next = PMAX;
      else if (w_pend_sum < -PMAX_E)
         w_pend_next = PMIN;
      else
         w_pend_next = PW'(w_pend_sum);
   end

   always_comb begin
      w_sum = $signed({{(SW-Y_W){1'b0}}, r_y}) + SW'(r_pend) * STEP_S;
      if (w_sum[SW-1])
         w_y_next = '0;
      else if (w_sum > YMAX_S)
         w_y_next = YMAX;
      else
         w_y_next = w_sum[Y_W-1:0];
   end

   always_ff @(posedge clk) begin
      if (reset || recenter) begin
         r_y    <= Y_RST;
         r_pend <= '0;
      end else begin
         r_pend <= w_pend_next;
         if (frame_tick)
            r_y <= w_y_next;
      end
   end

   assign y = r_y;

endmodule

// File: rtl/paddle_serve_ctrl.sv
// paddle_serve_ctrl: two-player paddle and serve controller for Pong.
//   Two paddle_axis instances track paddle Y; a match FSM sequences
//   serve / rally / point hold / game over from buttons and point reports.
// Ports:
//   clk, reset                 - clock, synchronous active-high reset
//   frame_tick                 - one-cycle pulse per frame
//   up_l, down_l, button_l     - left player controls
//   up_r, down_r, button_r     - right player controls
//   point_l, point_r           - one-cycle pulse, left/right player scored
//   paddle_y_l, paddle_y_r     - paddle top edges
//   score_l, score_r           - scores
//   serve_side                 - 0 = left serves, 1 = right serves
//   serve_go                   - one-cycle ball launch pulse
//   ball_enable                - ball may move/collide
//   game_over                  - high in GAME_OVER
module paddle_serve_ctrl
   import pong_pkg::*;
#(
   parameter int FIELD_H     = FIELD_H_DEF,
   parameter int PADDLE_H    = PADDLE_H_DEF,
   parameter int STEP        = 8,
   parameter int MAX_PENDING = 7,
   parameter int HOLD_FRAMES = 60,
   parameter int WIN_SCORE   = 9,
   parameter int Y_W         = Y_W_DEF
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           frame_tick,
   input  logic           up_l,
   input  logic           down_l,
   input  logic           button_l,
   input  logic           up_r,
   input  logic           down_r,
   input  logic           button_r,
   input  logic           point_l,
   input  logic           point_r,
   output logic [Y_W-1:0] paddle_y_l,
   output logic [Y_W-1:0] paddle_y_r,
   output logic [3:0]     score_l,
   output logic [3:0]     score_r,
   output logic           serve_side,
   output logic           serve_go,
   output logic           ball_enable,
   output logic           game_over
);

   localparam int         HW        = $clog2(HOLD_FRAMES + 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_FRAMES - 1);
   localparam logic [3:0] WIN       = 4'(WIN_SCORE);

   match_state_t  r_state;
   logic [HW-1:0] r_hold;
   logic [3:0]    r_score_l, r_score_r;
   logic          r_btn_l_q, r_btn_r_q;
   logic          r_serve_side, r_serve_go, r_ball_en, r_game_over;

   logic w_rise_l, w_rise_r, w_serve_rise, w_recenter;

   assign w_rise_l     = button_l && !r_btn_l_q;
   assign w_rise_r     = button_r && !r_btn_r_q;
   assign w_serve_rise = r_serve_side ? w_rise_r : w_rise_l;
   assign w_recenter   = (r_state == GAME_OVER) && (w_rise_l || w_rise_r);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= SERVE_WAIT;
         r_hold       <= '0;
         r_score_l    <= '0;
         r_score_r    <= '0;
         // History of 1 keeps a button held through reset from serving.
         r_btn_l_q    <= 1'b1;
         r_btn_r_q    <= 1'b1;
         r_serve_side <= 1'b0;
         r_serve_go   <= 1'b0;
         r_ball_en    <= 1'b0;
         r_game_over  <= 1'b0;
      end else begin
         r_btn_l_q  <= button_l;
         r_btn_r_q  <= button_r;
         r_serve_go <= 1'b0;
         case (r_state)
            SERVE_WAIT: begin
               if (w_serve_rise) begin
                  r_serve_go <= 1'b1;
                  r_ball_en  <= 1'b1;
                  r_state    <= PLAY;
               end
            end
            PLAY: begin
               r_hold <= '0;
               if (point_l && point_r) begin
                  // Simultaneous points cancel: no score, same server.
                  r_ball_en <= 1'b0;
                  r_state   <= POINT;
               end else if (point_l) begin
                  r_score_l    <= r_score_l + 4'd1;
                  r_serve_side <= 1'b1;
                  r_ball_en    <= 1'b0;
                  if (r_score_l + 4'd1 == WIN) begin
                     r_game_over <= 1'b1;
                     r_state     <= GAME_OVER;
                  end else begin
                     r_state <= POINT;
                  end
               end else if (point_r) begin
                  r_score_r    <= r_score_r + 4'd1;
                  r_serve_side <= 1'b0;
                  r_ball_en    <= 1'b0;
                  if (r_score_r + 4'd1 == WIN) begin
                     r_game_over <= 1'b1;
                     r_state     <= GAME_OVER;
                  end else begin
                     r_state <= POINT;
                  end
               end
            end
            POINT: begin
               if (frame_tick) begin
                  if (r_hold == HOLD_LAST) begin
                     r_hold  <= '0;
                     r_state <= SERVE_WAIT;
                  end else begin
                     r_hold <= r_hold + 1'b1;
                  end
               end
            end
            GAME_OVER: begin
               if (w_recenter) begin
                  r_score_l    <= '0;
                  r_score_r    <= '0;
                  r_serve_side <= 1'b0;
                  r_game_over  <= 1'b0;
                  r_state      <= SERVE_WAIT;
               end
            end
            default: r_state <= SERVE_WAIT;
         endcase
      end
   end

   paddle_axis #(
      .FIELD_H(FIELD_H), .PADDLE_H(PADDLE_H), .STEP(STEP),
      .MAX_PENDING(MAX_PENDING), .Y_W(Y_W)
   ) u_axis_l (
      .clk(clk), .reset(reset), .frame_tick(frame_tick),
      .up(up_l), .down(down_l), .recenter(w_recenter), .y(paddle_y_l)
   );

   paddle_axis #(
      .FIELD_H(FIELD_H), .PADDLE_H(PADDLE_H), .STEP(STEP),
      .MAX_PENDING(MAX_PENDING), .Y_W(Y_W)
   ) u_axis_r (
      .clk(clk), .reset(reset), .frame_tick(frame_tick),
      .up(up_r), .down(down_r), .recenter(w_recenter), .y(paddle_y_r)
   );

   assign score_l     = r_score_l;
   assign score_r     = r_score_r;
   assign serve_side  = r_serve_side;
   assign serve_go    = r_serve_go;
   assign ball_enable = r_ball_en;
   assign game_over   = r_game_over;

endmodule

// File: doc/paddle_serve_ctrl.md
# paddle_serve_ctrl

Two-player paddle and serve controller for Pong. It sits between the two `player_input` decoders and the ball/score datapath. It turns each player's one-cycle `up`/`down` step pulses into a clamped paddle Y position that updates once per video frame. A match FSM sequences serve, rally, point hold and game over, using the players' buttons and the ball engine's point reports.

## Interface
Parameters:
- `FIELD_H`, 480: playfield height in pixels.
- `PADDLE_H`, 64: paddle height in pixels.
- `STEP`, 8: pixels moved per accumulated step.
- `MAX_PENDING`, 7: saturation magnitude of the per-frame step accumulator.
- `HOLD_FRAMES`, 60: frames to pause after a point.
- `WIN_SCORE`, 9: score that ends the match (≤15).
- `Y_W`, 10: width of Y outputs.

Ports:
- `clk` input 1: system clock. Everything is registered on the rising edge.
- `reset` input 1: synchronous, active-high reset.
- `frame_tick` input 1: one-cycle pulse per frame (start of vblank).
- `up_l`, `down_l`, `button_l` input 1 each: left player, from `player_input`.
- `up_r`, `down_r`, `button_r` input 1 each: right player.
- `point_l`, `point_r` input 1 each: one-cycle pulse, left/right player scored.
- `paddle_y_l`, `paddle_y_r` output Y_W each: top edge of each paddle.
- `score_l`, `score_r` output 4 each: current scores.
- `serve_side` output 1: 0 = left serves, 1 = right serves.
- `serve_go` output 1: one-cycle launch pulse to the ball engine.
- `ball_enable` output 1: ball may move/collide.
- `game_over` output 1: high in GAME_OVER.

## Operation
- Per-player signed accumulator `pend`, range −MAX_PENDING..+MAX_PENDING.
  - `up` decrements it (toward y=0); `down` increments it.
  - `up` and `down` in the same cycle: no change.
  - Saturates at both limits.
- On `frame_tick`: y ← clamp(y + pend·STEP, 0, FIELD_H−PADDLE_H) and `pend` is cleared.
  - A pulse arriving in the tick cycle becomes the new `pend`; it is not lost and not applied this frame.
  - Intermediate arithmetic is signed, at least Y_W+2 bits wide.
- Paddles move in every FSM state.
- FSM states: SERVE_WAIT, PLAY, POINT, GAME_OVER.
  - **SERVE_WAIT:** a rising edge of the serving player's button (the button selected by `serve_side`) pulses `serve_go`, sets `ball_enable`, and moves to PLAY. The other player's button is ignored.
  - **PLAY:** `point_l` increments `score_l` and sets `serve_side`=1; `point_r` is symmetric. The conceding player serves next.
  - **PLAY, both points in the same cycle:** scores and `serve_side` are unchanged, and the FSM still goes to POINT.
  - **PLAY, after a point:** if the new score equals WIN_SCORE the FSM goes to GAME_OVER, otherwise to POINT. `ball_enable` clears either way.
  - **POINT:** counts HOLD_FRAMES `frame_tick`s, then goes to SERVE_WAIT.
  - **GAME_OVER:** a rising edge on either button clears the scores, sets `serve_side`=0, recenters both paddles, and moves to SERVE_WAIT.
- `point_*` inputs are ignored outside PLAY.
- Button edge detection: button high now and low in the previous registered sample.

## Timing
- Reset values, applied at the clock edge where `reset`=1 regardless of state:
  - `paddle_y_*` = (FIELD_H−PADDLE_H)/2 = 208.
  - `pend` = 0, scores = 0.
  - `serve_side`=0, `serve_go`=0, `ball_enable`=0, `game_over`=0.
  - State = SERVE_WAIT, hold counter = 0.
  - Button history = 1, so a button held through reset does not serve.
- `paddle_y_*` changes on the edge that samples `frame_tick`; the new value is visible the following cycle.
- `serve_go`/`ball_enable` go high in the cycle after the edge that samples the button rising. `serve_go` is high for exactly one cycle.
- Score and `ball_enable` fall in the cycle after the edge that samples `point_*`. `game_over` rises in that same cycle when WIN_SCORE is reached.
- POINT → SERVE_WAIT happens on the edge sampling the HOLD_FRAMES-th tick after entering POINT. A tick in the entry cycle does not count.

## Structure
- Shared package `pong_pkg` holds:
  - the state enum `match_state_t`;
  - defaults for FIELD_H, PADDLE_H and Y_W, which the ball and video blocks use too;
  - the `PADDLE_Y_RESET` constant.
- One sub-module, `paddle_axis`, instantiated twice. It owns the accumulator, clamp and Y register, and takes `frame_tick`, `up`, `down`, and a `recenter` strobe from GAME_OVER exit.
- The FSM, scores and button edge detectors live in the top level.

## Test plan
- **Accumulate and apply:** after reset, 3 `down_l` pulses then `frame_tick` → `paddle_y_l`=232 the next cycle, `pend` cleared.
- **Saturation:** 10 `up_r` pulses then tick → y=208−56=152. 30 more frames of 7 steps each → y clamps at 0, never wraps. Mirror test clamps at 416.
- **Simultaneous events:** `up_l`+`down_l` together change nothing. A `down_l` in the tick cycle is applied at the next tick.
- **Serve and point:** `button_r` in SERVE_WAIT → no serve. `button_l` rise → one-cycle `serve_go`, `ball_enable`=1. `point_l` → `score_l`=1, `serve_side`=1, `ball_enable`=0, SERVE_WAIT after 60 ticks.
- **Game over:** drive the left score to 9 → `game_over`=1 and further `point_*` are ignored. `button_r` edge → scores 0, paddles 208, SERVE_WAIT.
- **Reset mid-rally:** `reset` high while in PLAY with a button held → all outputs at reset values. No serve until the button is released and pressed again.
